// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
//   Round-robin arbiter that shares the single register-file write port among
//   NUM_REQ write-back requesters (ALU, load unit, mul/div, ...). Each
//   requester uses a valid/ready handshake. The winning request is captured
//   into a registered output stage that drives the register-file write inputs.
//   Writes to x0 are accepted but never reach the register file. They are
//   counted in a saturating drop counter instead.
//
// Ports
//   sys_clk_i      : single clock, all state on the rising edge
//   rst_n_i        : asynchronous active-low reset
//   req_valid_i    : per-requester write request
//   req_ready_o    : per-requester grant, one-hot or zero (combinational)
//   req_waddr_i    : packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   req_wdata_i    : packed data, requester k at [k*DATA_W +: DATA_W]
//   wb_hold_i      : blocks new grants while high
//   rd_waddr_o     : register-file write address (registered)
//   rd_wdata_o     : register-file write data (registered)
//   rd_wr_en_o     : register-file write enable, one pulse per accepted write
//   x0_drop_cnt_o  : saturating count of accepted writes that target x0
module regs_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int PTR_W   = 3
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_waddr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  input  logic                      wb_hold_i,
  output logic [ADDR_W-1:0]         rd_waddr_o,
  output logic [DATA_W-1:0]         rd_wdata_o,
  output logic                      rd_wr_en_o,
  output logic [7:0]                x0_drop_cnt_o
);

  logic [PTR_W-1:0]  ptr;
  logic              gnt_vld_p0;
  logic [PTR_W-1:0]  gnt_idx_p0;
  logic [ADDR_W-1:0] gnt_addr_p0;
  logic [DATA_W-1:0] gnt_data_p0;
  logic              gnt_x0_p0;
  logic [PTR_W-1:0]  ptr_nxt_p0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0: combinational grant search
  // The scan runs in two passes: indices from ptr upward, then the indices
  // below ptr. This equals a modulo-NUM_REQ rotation and avoids
  // variable-index arithmetic on the request vector.
  always_comb begin
    gnt_vld_p0  = 1'b0;
    gnt_idx_p0  = '0;
    gnt_addr_p0 = '0;
    gnt_data_p0 = '0;
    req_ready_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld_p0 && (k >= int'(ptr)) && req_valid_i[k]) begin
        gnt_vld_p0  = 1'b1;
        gnt_idx_p0  = PTR_W'(k);
        gnt_addr_p0 = req_waddr_i[k*ADDR_W +: ADDR_W];
        gnt_data_p0 = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld_p0 && (k < int'(ptr)) && req_valid_i[k]) begin
        gnt_vld_p0  = 1'b1;
        gnt_idx_p0  = PTR_W'(k);
        gnt_addr_p0 = req_waddr_i[k*ADDR_W +: ADDR_W];
        gnt_data_p0 = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
    // Hold only blocks new grants. A write already in the output stage still completes.
    if (wb_hold_i) gnt_vld_p0 = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready_o[k] = gnt_vld_p0 && (gnt_idx_p0 == PTR_W'(k));
    end
  end

  assign gnt_x0_p0  = (gnt_addr_p0 == '0);
  assign ptr_nxt_p0 = (gnt_idx_p0 == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx_p0 + 1'b1;

  // Stage p1: registered register-file write port
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr           <= '0;
      rd_wr_en_o    <= 1'b0;
      rd_waddr_o    <= '0;
      rd_wdata_o    <= '0;
      x0_drop_cnt_o <= '0;
    end else begin
      rd_wr_en_o <= 1'b0;
      if (gnt_vld_p0) begin
        ptr        <= ptr_nxt_p0;
        rd_waddr_o <= gnt_addr_p0;
        rd_wdata_o <= gnt_data_p0;
        // An x0 write is consumed without a register-file write.
        rd_wr_en_o <= !gnt_x0_p0;
        if (gnt_x0_p0) x0_drop_cnt_o <= sat_inc8(x0_drop_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Testbench for regs_wb_arbiter. Directed stimulus pushes the expected
// register-file writes into a queue. A monitor pops the queue and compares
// whenever the DUT presents rd_wr_en_o.
module tb_regs_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int PTR_W   = 3;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_REQ-1:0]        valid = '0;
  logic [NUM_REQ-1:0]        ready;
  logic [NUM_REQ*ADDR_W-1:0] waddr_bus;
  logic [NUM_REQ*DATA_W-1:0] wdata_bus;
  logic                      hold = 1'b0;
  logic [ADDR_W-1:0]         rd_waddr;
  logic [DATA_W-1:0]         rd_wdata;
  logic                      rd_wr_en;
  logic [7:0]                drop_cnt;

  logic [ADDR_W-1:0] addr_t [NUM_REQ];
  logic [DATA_W-1:0] data_t [NUM_REQ];

  wr_t              q[$];
  wr_t              mon_e;
  logic [NUM_REQ-1:0] pend = '0;
  int               n_chk = 0;
  int               n_fail = 0;

  regs_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_W(PTR_W)
  ) dut (
    .sys_clk_i    (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (valid),
    .req_ready_o  (ready),
    .req_waddr_i  (waddr_bus),
    .req_wdata_i  (wdata_bus),
    .wb_hold_i    (hold),
    .rd_waddr_o   (rd_waddr),
    .rd_wdata_o   (rd_wdata),
    .rd_wr_en_o   (rd_wr_en),
    .x0_drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    waddr_bus = '0;
    wdata_bus = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      waddr_bus[k*ADDR_W +: ADDR_W] = addr_t[k];
      wdata_bus[k*DATA_W +: DATA_W] = data_t[k];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write enable must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rd_wr_en) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rd_waddr, rd_wdata);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr", 64'(rd_waddr), 64'(mon_e.a));
        chk("wr_data", 64'(rd_wdata), 64'(mon_e.d));
      end
    end
  end

  // Protocol watch: a requester must not drop valid before being granted.
  always @(negedge clk) begin
    if (!rst_n) pend = '0;
    else begin
      if ((pend & ~valid) != '0) begin
        n_chk++;
        n_fail++;
        $display("FAIL valid_drop: got valid %b expected pending %b held", valid, pend);
      end
      pend = valid & ~ready;
    end
  end

  task automatic set_req(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addr_t[k] = a;
    data_t[k] = d;
  endtask

  // One cycle: drive, check the combinational grant, queue the expected write.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic h,
                      input logic [NUM_REQ-1:0] exp_rdy, input string name);
    valid = v;
    hold  = h;
    @(negedge clk);
    chk({name, "_ready"}, 64'(ready), 64'(exp_rdy));
    for (int k = 0; k < NUM_REQ; k++) begin
      if (exp_rdy[k] && addr_t[k] != '0) q.push_back('{addr_t[k], data_t[k]});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < NUM_REQ; k++) set_req(k, '0, '0);
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr_en", 64'(rd_wr_en), 64'd0);
    chk("rst_waddr", 64'(rd_waddr), 64'd0);
    chk("rst_wdata", 64'(rd_wdata), 64'd0);
    chk("rst_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single requester
    set_req(1, 5'd5, 32'hDEADBEEF);
    step(3'b010, 1'b0, 3'b010, "single");
    step(3'b000, 1'b0, 3'b000, "single_idle");
    step(3'b000, 1'b0, 3'b000, "single_idle2");

    // Round-robin wrap from ptr=2
    set_req(0, 5'd3, 32'hA0A0_0000);
    set_req(1, 5'd4, 32'hA1A1_1111);
    set_req(2, 5'd6, 32'hA2A2_2222);
    step(3'b101, 1'b0, 3'b100, "wrap_r2");
    step(3'b101, 1'b0, 3'b001, "wrap_r0");
    step(3'b111, 1'b0, 3'b010, "wrap_ptr1");
    step(3'b101, 1'b0, 3'b100, "wrap_ptr2");
    step(3'b001, 1'b0, 3'b001, "wrap_last");
    step(3'b000, 1'b0, 3'b000, "wrap_idle");

    // x0 squash and saturation
    set_req(0, 5'd0, 32'h0000_1234);
    for (int i = 0; i < 3; i++) step(3'b001, 1'b0, 3'b001, "x0");
    step(3'b000, 1'b0, 3'b000, "x0_idle");
    chk("x0_cnt3", 64'(drop_cnt), 64'd3);
    for (int i = 0; i < 297; i++) step(3'b001, 1'b0, 3'b001, "x0_sat");
    step(3'b000, 1'b0, 3'b000, "x0_idle2");
    chk("x0_cnt_sat", 64'(drop_cnt), 64'd255);

    // Hold: the write accepted just before hold still completes
    set_req(0, 5'd10, 32'h0000_00C0);
    set_req(1, 5'd11, 32'h0000_00C1);
    set_req(2, 5'd9,  32'h0000_00C2);
    step(3'b100, 1'b0, 3'b100, "hold_pre");
    for (int i = 0; i < 4; i++) step(3'b011, 1'b1, 3'b000, "hold");
    chk("hold_no_wr", 64'(rd_wr_en), 64'd0);
    step(3'b011, 1'b0, 3'b001, "hold_rel0");
    step(3'b010, 1'b0, 3'b010, "hold_rel1");
    step(3'b000, 1'b0, 3'b000, "hold_idle");
    step(3'b000, 1'b0, 3'b000, "hold_idle2");

    // Reset mid-write
    set_req(0, 5'd7, 32'h0000_0077);
    step(3'b001, 1'b0, 3'b001, "midrst");
    chk("midrst_wr_en_hi", 64'(rd_wr_en), 64'd1);
    chk("midrst_waddr", 64'(rd_waddr), 64'd7);
    valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en_lo", 64'(rd_wr_en), 64'd0);
    chk("midrst_waddr0", 64'(rd_waddr), 64'd0);
    chk("midrst_wdata0", 64'(rd_wdata), 64'd0);
    chk("midrst_cnt0", 64'(drop_cnt), 64'd0);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("postrst_cnt", 64'(drop_cnt), 64'd0);

    // All three continuously valid from reset
    set_req(0, 5'd1, 32'h0000_0011);
    set_req(1, 5'd2, 32'h0000_0022);
    set_req(2, 5'd3, 32'h0000_0033);
    for (int r = 0; r < 2; r++) begin
      step(3'b111, 1'b0, 3'b001, "all_g0");
      step(3'b111, 1'b0, 3'b010, "all_g1");
      step(3'b111, 1'b0, 3'b100, "all_g2");
    end
    step(3'b011, 1'b0, 3'b001, "all_tail0");
    step(3'b010, 1'b0, 3'b010, "all_tail1");
    step(3'b000, 1'b0, 3'b000, "all_idle");
    step(3'b000, 1'b0, 3'b000, "all_idle2");
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the single register-file write port (rd_waddr/rd_wdata/rd_wr_en) among NUM_REQ write-back requesters, e.g. ALU, load unit and mul/div.
- Arbitration is round-robin; requesters use a valid/ready handshake.
- Sits between the execute/memory stages and the register file. Drives the register-file write inputs from a registered output stage.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8); index 0 is highest at reset.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- PTR_W, 3, round-robin pointer width; must satisfy 2**PTR_W >= NUM_REQ.

Ports:
- sys_clk_i  in  1  single clock; all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_ready_o  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_waddr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at bits [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_REQ*DATA_W  packed data; requester k at bits [k*DATA_W +: DATA_W].
- wb_hold_i  in  1  suspend granting; no requester is accepted while high.
- rd_waddr_o  out  ADDR_W  register-file write address (registered).
- rd_wdata_o  out  DATA_W  register-file write data (registered).
- rd_wr_en_o  out  1  register-file write enable, one-cycle pulse per accepted write.
- x0_drop_cnt_o  out  8  saturating count of accepted writes targeting x0.

Behaviour:
- Reset: asserting rst_n_i low forces the following immediately (asynchronous).
  - rd_wr_en_o=0, rd_waddr_o=0, rd_wdata_o=0, x0_drop_cnt_o=0.
  - Round-robin pointer=0.
  - Any accepted-but-unwritten entry is discarded.
- Grant search, combinational:
  - Scan indices ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - The first k with req_valid_i[k]=1 is granted: req_ready_o[k]=1.
  - With wb_hold_i=1 or no valid request, req_ready_o is all zeros.
  - req_ready_o may depend combinationally on req_valid_i and wb_hold_i only.
- Transfer: the transfer occurs on a clock edge where req_valid_i[k] and req_ready_o[k] are both 1. The requester must hold valid/addr/data stable until that edge.
- Latency: exactly 1 cycle. The edge of acceptance loads rd_waddr_o and rd_wdata_o from requester k. The same edge sets rd_wr_en_o=1 unless the address is 0.
- No transfer in a cycle: rd_wr_en_o=0 on the next cycle. rd_waddr_o and rd_wdata_o hold their last values.
- Pointer: on a grant to k, ptr <= (k+1) mod NUM_REQ, with wrap from NUM_REQ-1 to 0. There is no update without a grant.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles while wb_hold_i=0.
- x0 squash:
  - An accepted request with address 0 is consumed: ready=1 and the pointer advances.
  - rd_wr_en_o stays 0 for it.
  - x0_drop_cnt_o increments by 1 and saturates at 255.
- Same address from several requesters in one cycle: only the granted one is written. The others wait. Write order follows the grant order.
- wb_hold_i asserted while rd_wr_en_o=1: the already-accepted write still completes that cycle. Only new grants are blocked.
- Throughput: one write per cycle maximum. Back-to-back grants to different requesters are allowed.
- Requester deasserting valid before being granted is illegal. The bench flags it; the RTL behaviour in that case is unspecified.

Test Plan:
- Reset mid-write: assert rst_n_i low while rd_wr_en_o=1 -> rd_wr_en_o drops without waiting for a clock edge; after release, ptr=0 and x0_drop_cnt_o=0.
- Single requester: req1 valid, addr 5, data 0xDEADBEEF -> req_ready_o=3'b010 in the same cycle; next cycle rd_wr_en_o=1, rd_waddr_o=5, rd_wdata_o=0xDEADBEEF; then rd_wr_en_o=0.
- All three valid continuously from reset with distinct addresses 1/2/3 -> grant order 0,1,2,0,1,2; rd_wr_en_o high every cycle; addresses seen 1,2,3,1,...
- Round-robin wrap: ptr=2 and only req0 and req2 valid -> req2 granted first, then req0; ptr ends at 1.
- x0 squash: req0 writes addr 0 three times -> three ready pulses, rd_wr_en_o stays 0, x0_drop_cnt_o=3; after 300 such writes the count stays at 255.
- Hold: wb_hold_i=1 for 4 cycles with req0 and req1 valid -> req_ready_o=0 during hold; the pending write still pulses once; after release req0 is granted first, then req1 one cycle later.
